// File: rtl/alsu_drv_pkg.sv
// Shared types for the ALSU command driver: opcode encoding, command and
// response records, the idle (NOP) drive value and the invalid-command test.
package alsu_drv_pkg;

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_ADD    = 3'd2,
        OP_MULT   = 3'd3,
        OP_SHIFT  = 3'd4,
        OP_ROTATE = 3'd5,
        OP_INV6   = 3'd6,
        OP_INV7   = 3'd7
    } opcode_e;

    typedef struct packed {
        opcode_e           opcode;
        logic signed [2:0] a;
        logic signed [2:0] b;
        logic              cin;
        logic              serial_in;
        logic              red_op_a;
        logic              red_op_b;
        logic              bypass_a;
        logic              bypass_b;
        logic              direction;
    } alsu_cmd_t;

    typedef struct packed {
        logic signed [5:0] out;
        logic [15:0]       leds;
        logic              invalid;
    } alsu_rsp_t;

    // Bypassing a zero A operand forces the ALSU result to 0 between commands.
    localparam alsu_cmd_t NOP_CMD = '{
        opcode: OP_AND, a: 3'sd0, b: 3'sd0, cin: 1'b0, serial_in: 1'b0,
        red_op_a: 1'b0, red_op_b: 1'b0, bypass_a: 1'b1, bypass_b: 1'b0,
        direction: 1'b0
    };

    function automatic logic cmd_invalid(input alsu_cmd_t c);
        return (c.opcode == OP_INV6) || (c.opcode == OP_INV7) ||
               ((c.red_op_a || c.red_op_b) && (c.opcode > OP_OR));
    endfunction

endpackage

// File: rtl/alsu_drv_rsp_fifo.sv
// Synchronous response FIFO; the head reads as zero while empty so the
// response fields stay quiet when nothing is valid.
module alsu_drv_rsp_fifo
    import alsu_drv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  alsu_rsp_t              wr_data,
    input  logic                   pop,
    output alsu_rsp_t              rd_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    alsu_rsp_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/alsu_driver.sv
// Command-side initiator for the ALSU with credit-based response tracking.
// Define ALSU_DRIVER_STATS_EN to add saturating command/invalid counters.
module alsu_driver
    import alsu_drv_pkg::*;
#(
    parameter int ALSU_LAT  = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_opcode,
    input  logic signed [2:0] cmd_a,
    input  logic signed [2:0] cmd_b,
    input  logic              cmd_cin,
    input  logic              cmd_serial_in,
    input  logic              cmd_red_op_a,
    input  logic              cmd_red_op_b,
    input  logic              cmd_bypass_a,
    input  logic              cmd_bypass_b,
    input  logic              cmd_direction,
    output logic signed [2:0] A,
    output logic signed [2:0] B,
    output logic [2:0]        opcode,
    output logic              cin,
    output logic              serial_in,
    output logic              red_op_A,
    output logic              red_op_B,
    output logic              bypass_A,
    output logic              bypass_B,
    output logic              direction,
    input  logic signed [5:0] out,
    input  logic [15:0]       leds,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic signed [5:0] rsp_out,
    output logic [15:0]       rsp_leds,
    output logic              rsp_invalid
`ifdef ALSU_DRIVER_STATS_EN
    ,
    output logic [15:0]       stat_cmd_cnt,
    output logic [15:0]       stat_inv_cnt
`endif
);
    localparam int FCW = $clog2(RSP_DEPTH) + 1;
    localparam int CW  = $clog2(RSP_DEPTH + ALSU_LAT + 2);

    alsu_cmd_t       cmd;
    alsu_cmd_t       drv;
    logic            accept;
    logic            cmd_inv;
    logic [ALSU_LAT:0] vld_pipe;
    logic [ALSU_LAT:0] inv_pipe;
    logic [CW-1:0]   inflight;
    logic [FCW-1:0]  fifo_count;
    alsu_rsp_t       push_rsp;
    alsu_rsp_t       head;
    logic            pop;

    assign cmd = '{
        opcode: opcode_e'(cmd_opcode), a: cmd_a, b: cmd_b, cin: cmd_cin,
        serial_in: cmd_serial_in, red_op_a: cmd_red_op_a,
        red_op_b: cmd_red_op_b, bypass_a: cmd_bypass_a,
        bypass_b: cmd_bypass_b, direction: cmd_direction
    };
    assign cmd_inv = cmd_invalid(cmd);

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= ALSU_LAT; i++) inflight = inflight + CW'(vld_pipe[i]);
    end

    // Every in-flight command already owns a FIFO slot, so a push never overflows.
    assign cmd_ready = !rst &&
        ((CW+1)'(inflight) + (CW+1)'(fifo_count) < (CW+1)'(RSP_DEPTH));
    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (rst || !accept) drv <= NOP_CMD;
        else                drv <= cmd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            inv_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[ALSU_LAT-1:0], accept};
            inv_pipe <= {inv_pipe[ALSU_LAT-1:0], accept && cmd_inv};
        end
    end

    assign push_rsp = '{out: out, leds: leds, invalid: inv_pipe[ALSU_LAT]};
    assign pop      = rsp_valid && rsp_ready;

    alsu_drv_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (vld_pipe[ALSU_LAT]),
        .wr_data (push_rsp),
        .pop     (pop),
        .rd_data (head),
        .count   (fifo_count)
    );

    assign rsp_valid   = (fifo_count != '0);
    assign rsp_out     = head.out;
    assign rsp_leds    = head.leds;
    assign rsp_invalid = head.invalid;

    assign A         = drv.a;
    assign B         = drv.b;
    assign opcode    = drv.opcode;
    assign cin       = drv.cin;
    assign serial_in = drv.serial_in;
    assign red_op_A  = drv.red_op_a;
    assign red_op_B  = drv.red_op_b;
    assign bypass_A  = drv.bypass_a;
    assign bypass_B  = drv.bypass_b;
    assign direction = drv.direction;

`ifdef ALSU_DRIVER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cmd_cnt <= '0;
            stat_inv_cnt <= '0;
        end else if (accept) begin
            if (stat_cmd_cnt != 16'hFFFF) stat_cmd_cnt <= stat_cmd_cnt + 16'd1;
            if (cmd_inv && stat_inv_cnt != 16'hFFFF) stat_inv_cnt <= stat_inv_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alsu_driver.sv
// Directed bench for alsu_driver with a small behavioural ALSU (two-stage,
// registered inputs then registered result) attached to the drive pins.
module tb_alsu_driver;
    import alsu_drv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic cmd_valid, cmd_ready;
    logic [2:0] cmd_opcode;
    logic signed [2:0] cmd_a, cmd_b;
    logic cmd_cin, cmd_serial_in, cmd_red_op_a, cmd_red_op_b;
    logic cmd_bypass_a, cmd_bypass_b, cmd_direction;
    logic signed [2:0] A, B;
    logic [2:0] opcode;
    logic cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction;
    logic signed [5:0] alsu_out;
    logic [15:0] alsu_leds;
    logic rsp_valid, rsp_ready, rsp_invalid;
    logic signed [5:0] rsp_out;
    logic [15:0] rsp_leds;
`ifdef ALSU_DRIVER_STATS_EN
    logic [15:0] stat_cmd_cnt, stat_inv_cnt;
`endif

    alsu_driver dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
        .cmd_serial_in(cmd_serial_in), .cmd_red_op_a(cmd_red_op_a),
        .cmd_red_op_b(cmd_red_op_b), .cmd_bypass_a(cmd_bypass_a),
        .cmd_bypass_b(cmd_bypass_b), .cmd_direction(cmd_direction),
        .A(A), .B(B), .opcode(opcode), .cin(cin), .serial_in(serial_in),
        .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A),
        .bypass_B(bypass_B), .direction(direction),
        .out(alsu_out), .leds(alsu_leds),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
        .rsp_leds(rsp_leds), .rsp_invalid(rsp_invalid)
`ifdef ALSU_DRIVER_STATS_EN
        , .stat_cmd_cnt(stat_cmd_cnt), .stat_inv_cnt(stat_inv_cnt)
`endif
    );

    // ---- behavioural ALSU ----
    logic signed [2:0] a_r, b_r;
    logic [2:0] op_r;
    logic cin_r, si_r, ra_r, rb_r, ba_r, bb_r, dir_r;

    function automatic logic signed [5:0] alsu_f(
        input logic [2:0] op, input logic signed [2:0] a, input logic signed [2:0] b,
        input logic ci, input logic si, input logic ra, input logic rb,
        input logic ba, input logic bb, input logic dir, input logic signed [5:0] prev);
        logic signed [5:0] ax, bx;
        logic inv;
        ax  = {{3{a[2]}}, a};
        bx  = {{3{b[2]}}, b};
        inv = (op > 3'd5) || ((ra || rb) && op > 3'd1);
        if (ba) return ax;
        if (bb) return bx;
        if (inv) return 6'sd0;
        case (op)
            3'd0: begin
                if (ra) return {5'b0, |a};
                if (rb) return {5'b0, |b};
                return ax & bx;
            end
            3'd1: begin
                if (ra) return {5'b0, ^a};
                if (rb) return {5'b0, ^b};
                return ax | bx;
            end
            3'd2: return ax + bx + {5'b0, ci};
            3'd3: return ax * bx;
            3'd4: return dir ? {prev[4:0], si} : {si, prev[5:1]};
            default: return dir ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r <= '0; b_r <= '0; op_r <= '0; cin_r <= 1'b0; si_r <= 1'b0;
            ra_r <= 1'b0; rb_r <= 1'b0; ba_r <= 1'b0; bb_r <= 1'b0; dir_r <= 1'b0;
        end else begin
            a_r <= A; b_r <= B; op_r <= opcode; cin_r <= cin; si_r <= serial_in;
            ra_r <= red_op_A; rb_r <= red_op_B; ba_r <= bypass_A; bb_r <= bypass_B;
            dir_r <= direction;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alsu_out  <= '0;
            alsu_leds <= '0;
        end else begin
            alsu_out  <= alsu_f(op_r, a_r, b_r, cin_r, si_r, ra_r, rb_r, ba_r, bb_r, dir_r, alsu_out);
            alsu_leds <= ((op_r > 3'd5) || ((ra_r || rb_r) && op_r > 3'd1)) ? 16'hFFFF : 16'h0000;
        end
    end

    // ---- checking ----
    typedef struct {
        string name;
        logic [2:0] op;
        logic signed [2:0] a, b;
        logic ci, si, ra, rb, ba, bb, dir;
        logic signed [5:0] eo;
        logic [15:0] el;
        logic ei;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input int op, input int a, input int b,
        input int ci, input int si, input int ra, input int rb, input int ba, input int bb,
        input int dir, input int eo, input int el, input int ei);
        vec_t v;
        v.name = name; v.op = 3'(op); v.a = 3'(a); v.b = 3'(b);
        v.ci = 1'(ci); v.si = 1'(si); v.ra = 1'(ra); v.rb = 1'(rb);
        v.ba = 1'(ba); v.bb = 1'(bb); v.dir = 1'(dir);
        v.eo = 6'(eo); v.el = 16'(el); v.ei = 1'(ei);
        return v;
    endfunction

    task automatic set_cmd(input vec_t v);
        cmd_opcode = v.op; cmd_a = v.a; cmd_b = v.b; cmd_cin = v.ci;
        cmd_serial_in = v.si; cmd_red_op_a = v.ra; cmd_red_op_b = v.rb;
        cmd_bypass_a = v.ba; cmd_bypass_b = v.bb; cmd_direction = v.dir;
    endtask

    // Returns 1 time unit after the accepting edge.
    task automatic issue(input vec_t v);
        int n = 0;
        set_cmd(v);
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!cmd_ready) begin
            check({v.name, "_ready_timeout"}, 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
    endtask

    task automatic check_rsp(input string name, input logic signed [5:0] eo,
                             input logic [15:0] el, input logic ei);
        check({name, "_valid"}, 32'(rsp_valid), 32'd1);
        check({name, "_out"}, 32'(rsp_out), 32'(eo));
        check({name, "_leds"}, 32'(rsp_leds), 32'(el));
        check({name, "_inv"}, 32'(rsp_invalid), 32'(ei));
    endtask

    vec_t vt [10];
    vec_t seq [3];
    int lat, k, got, seen;
    logic acc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        name          op  a   b  ci si ra rb ba bb dir  out  leds     inv
        vt[0] = mk("and",        0,  3, -2, 0, 0, 0, 0, 0, 0, 0,   2, 16'h0000, 0);
        vt[1] = mk("inv6",       6,  2,  1, 0, 0, 0, 0, 0, 0, 0,   0, 16'hFFFF, 1);
        vt[2] = mk("add_reda",   2,  1,  1, 0, 0, 1, 0, 0, 0, 0,   0, 16'hFFFF, 1);
        vt[3] = mk("add_cin",    2,  3,  2, 1, 0, 0, 0, 0, 0, 0,   6, 16'h0000, 0);
        vt[4] = mk("mult",       3, -3,  3, 0, 0, 0, 0, 0, 0, 0,  -9, 16'h0000, 0);
        vt[5] = mk("bypb",       0,  1, -4, 0, 0, 0, 0, 0, 1, 0,  -4, 16'h0000, 0);
        vt[6] = mk("inv7_bypa",  7,  1,  0, 0, 0, 0, 0, 1, 0, 0,   1, 16'hFFFF, 1);
        vt[7] = mk("or_reda",    1, -4,  0, 0, 0, 1, 0, 0, 0, 0,   1, 16'h0000, 0);
        vt[8] = mk("shift_idle", 4,  0,  0, 0, 1, 0, 0, 0, 0, 1,   1, 16'h0000, 0);
        vt[9] = mk("mult_neg",   3, -4, -4, 0, 0, 0, 0, 0, 0, 0,  16, 16'h0000, 0);

        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
        set_cmd(vt[0]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_bypass_A", 32'(bypass_A), 32'd1);
        check("post_rst_A", 32'(A), 32'd0);
        check("post_rst_rsp_out", 32'(rsp_out), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            issue(vt[i]);
            check({vt[i].name, "_drv_A"}, 32'(A), 32'(vt[i].a));
            check({vt[i].name, "_drv_op"}, 32'(opcode), 32'(vt[i].op));
            wait_rsp(lat);
            check({vt[i].name, "_latency"}, 32'(lat - 1), 32'd3);
            check_rsp(vt[i].name, vt[i].eo, vt[i].el, vt[i].ei);
            if (i == 0) begin
                check("idle_drv_bypass_A", 32'(bypass_A), 32'd1);
                @(negedge clk);
                check("single_popped", 32'(rsp_valid), 32'd0);
            end
            @(posedge clk); #1;
        end

        seq[0] = mk("b2b_or",   1,  1, 2, 0, 0, 0, 0, 0, 0, 0,  3, 0, 0);
        seq[1] = mk("b2b_bypa", 0, -3, 0, 0, 0, 0, 0, 1, 0, 0, -3, 0, 0);
        seq[2] = mk("b2b_redb", 0,  0, 4, 0, 0, 0, 1, 0, 0, 0,  1, 0, 0);
        for (int i = 0; i < 3; i++) issue(seq[i]);
        wait_rsp(lat);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check_rsp(seq[i].name, seq[i].eo, seq[i].el, seq[i].ei);
        end
        @(posedge clk); #1;

        // Back-to-back shift sees the ADD result (2) as its previous output.
        issue(mk("sh_add", 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
        issue(mk("sh_shift", 4, 0, 0, 0, 1, 0, 0, 0, 0, 1, 5, 0, 0));
        wait_rsp(lat);
        check_rsp("sh_add", 6'sd2, 16'h0, 1'b0);
        @(negedge clk);
        check_rsp("sh_shift", 6'sd5, 16'h0, 1'b0);
        @(posedge clk); #1;

        // Backpressure: six ADD a=k-2, b=0 commands with rsp_ready low.
        rsp_ready = 1'b0; k = 0;
        set_cmd(mk("bp", 2, -2, 0, 0, 0, 0, 0, 0, 0, 0, -2, 0, 0));
        cmd_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); acc = cmd_ready && (k < 6);
            @(posedge clk); #1;
            if (acc) begin
                k++;
                if (k < 6) set_cmd(mk("bp", 2, k - 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                else cmd_valid = 1'b0;
            end
        end
        check("bp_accepted", 32'(k), 32'd4);
        @(negedge clk);
        check("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
        check("bp_hold_out_a", 32'(rsp_out), 32'(-2));
        @(negedge clk);
        check("bp_hold_valid", 32'(rsp_valid), 32'd1);
        check("bp_hold_out_b", 32'(rsp_out), 32'(-2));
        @(posedge clk); #1;
        rsp_ready = 1'b1; got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(negedge clk); acc = cmd_ready && (k < 6);
            if (rsp_valid) begin
                check("bp_rsp_out", 32'(rsp_out), 32'(got - 2));
                got++;
            end
            @(posedge clk); #1;
            if (acc) begin
                k++;
                if (k < 6) set_cmd(mk("bp", 2, k - 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                else cmd_valid = 1'b0;
            end
        end
        check("bp_rsp_count", 32'(got), 32'd6);
        check("bp_all_accepted", 32'(k), 32'd6);

        // Reset one cycle after two accepts: nothing may come out.
        issue(mk("r1", 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        issue(mk("r2", 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("midrst_cmd_ready_after", 32'(cmd_ready), 32'd1);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_rsp_out", 32'(rsp_out), 32'd0);
        check("midrst_rsp_leds", 32'(rsp_leds), 32'd0);
        check("midrst_rsp_inv", 32'(rsp_invalid), 32'd0);
        check("midrst_bypass_A", 32'(bypass_A), 32'd1);
        check("midrst_A", 32'(A), 32'd0);
        check("midrst_opcode", 32'(opcode), 32'd0);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("midrst_no_rsp", 32'(seen), 32'd0);
        @(posedge clk); #1;

`ifdef ALSU_DRIVER_STATS_EN
        issue(vt[3]); issue(vt[1]); issue(vt[4]); issue(vt[2]); issue(vt[0]);
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("stat_cmd_cnt", 32'(stat_cmd_cnt), 32'd5);
        check("stat_inv_cnt", 32'(stat_inv_cnt), 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
